// File: rtl/count_sequence_monitor_pkg.sv
// Shared types and helpers for the count sequence monitor and its counter source.
package count_mon_pkg;

    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    // Successor of prev modulo 2^w; callers truncate to their own width.
    function automatic logic [31:0] next_count(input logic [31:0] prev, input int w = CNT_W_DEF);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (prev + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/count_sequence_monitor_if.sv
// Observation bus between the counter side (master) and the monitor (slave).
interface count_sequence_monitor_if
    import count_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEPTH  = 4,
    parameter int STAT_W = 8
);
    logic [CNT_W-1:0]       count_in;
    logic                   clear;
    logic                   locked;
    logic                   err_pulse;
    logic [STAT_W-1:0]      err_count;
    logic [STAT_W-1:0]      wrap_count;
    logic [CNT_W*DEPTH-1:0] history;

    modport master (
        output count_in, clear,
        input  locked, err_pulse, err_count, wrap_count, history
    );

    modport slave (
        input  count_in, clear,
        output locked, err_pulse, err_count, wrap_count, history
    );
endinterface

// File: rtl/count_sequence_monitor_history_sr.sv
// CNT_W x DEPTH sample history; newest sample lives in the low CNT_W bits.
module count_history_sr #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [CNT_W-1:0]       din,
    output logic [CNT_W*DEPTH-1:0] q
);

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or posedge reset) begin
                if (reset)         q <= '0;
                else if (clear)    q <= '0;
                else if (shift_en) q <= din;
            end
        end else begin : g_many
            always_ff @(posedge clk or posedge reset) begin
                if (reset)         q <= '0;
                else if (clear)    q <= '0;
                else if (shift_en) q <= {q[CNT_W*(DEPTH-1)-1:0], din};
            end
        end
    endgenerate

endmodule

// File: rtl/count_sequence_monitor.sv
// Checks that a free-running counter advances by one each clock; tracks lock,
// error and wrap statistics and keeps a short sample history.
module count_sequence_monitor
    import count_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEPTH  = 4,
    parameter int LOCK_N = 2,
    parameter int STAT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    count_sequence_monitor_if.slave  mon
);

    localparam int GC_W = $clog2(LOCK_N + 1);

    mon_state_t        state, state_nxt;
    logic [GC_W-1:0]   good_cnt, good_cnt_nxt, good_cnt_inc;
    logic [CNT_W-1:0]  prev, expect_cnt;
    logic              good, err_evt, wrap_evt;
    logic              locked_q, err_pulse_q;
    logic [STAT_W-1:0] err_count_q, wrap_count_q;

    assign expect_cnt   = CNT_W'(next_count(32'(prev), CNT_W));
    assign good         = (mon.count_in == expect_cnt);
    assign good_cnt_inc = good_cnt + GC_W'(1);

    // State register and the sample holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            good_cnt <= '0;
            prev     <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            if (!mon.clear) prev <= mon.count_in;
        end
    end

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        if (mon.clear) begin
            state_nxt    = IDLE;
            good_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt    = SYNC;
                    good_cnt_nxt = '0;
                end
                SYNC: begin
                    if (good) begin
                        good_cnt_nxt = good_cnt_inc;
                        if (good_cnt_inc == GC_W'(LOCK_N)) state_nxt = LOCKED;
                    end else begin
                        good_cnt_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (!good) begin
                        state_nxt    = SYNC;
                        good_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    good_cnt_nxt = '0;
                end
            endcase
        end
    end

    // A wrap is a good step out of the all-ones value, so it never coincides with an error.
    always_comb begin
        err_evt  = !mon.clear && (state == LOCKED) && !good;
        wrap_evt = !mon.clear && (state != IDLE) && good && (prev == '1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            locked_q    <= (state_nxt == LOCKED);
            err_pulse_q <= err_evt;
            if (mon.clear) begin
                err_count_q  <= '0;
                wrap_count_q <= '0;
            end else begin
                if (err_evt && (err_count_q != '1)) err_count_q <= err_count_q + STAT_W'(1);
                if (wrap_evt) wrap_count_q <= wrap_count_q + STAT_W'(1);
            end
        end
    end

    count_history_sr #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .clear    (mon.clear),
        .shift_en (1'b1),
        .din      (mon.count_in),
        .q        (mon.history)
    );

    assign mon.locked     = locked_q;
    assign mon.err_pulse  = err_pulse_q;
    assign mon.err_count  = err_count_q;
    assign mon.wrap_count = wrap_count_q;

endmodule

// File: doc/count_sequence_monitor.md
# count_sequence_monitor

Downstream consumer of the 3-bit free-running `binary_counter`. It samples the counter value every clock and checks that each sample is the previous sample plus one, modulo 2^CNT_W. It tracks lock status, counts sequence errors and roll-overs, and keeps a shift-register history of the last DEPTH samples for debug readout. The block is pure observation logic and never back-pressures the counter.

## Interface
- CNT_W, 3, width of the observed count
- DEPTH, 4, number of samples held in history
- LOCK_N, 2, consecutive good steps required to declare lock (≥1)
- STAT_W, 8, width of err_count and wrap_count
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- count_in  in  CNT_W  counter value from binary_counter
- clear  in  1  synchronous clear of state, stats and history
- locked  out  1  high while sequence is verified
- err_pulse  out  1  one-cycle pulse per error detected while locked
- err_count  out  STAT_W  errors seen while locked, saturating
- wrap_count  out  STAT_W  good (2^CNT_W−1)→0 steps, wrapping
- history  out  CNT_W*DEPTH  last DEPTH samples; [CNT_W-1:0] is the newest

## Operation
- States:
  - IDLE: no previous sample.
  - SYNC: previous sample held; counting good steps in good_cnt.
  - LOCKED: sequence verified.
- "Good step": count_in == (prev + 1) mod 2^CNT_W. A repeated value is a mismatch.
- Sampling at every rising edge, unless clear or reset is active:
  - prev ← count_in.
  - history shifts left by CNT_W and the new sample enters at [CNT_W-1:0].
- IDLE → SYNC on the first sample; good_cnt ← 0.
- In SYNC:
  - A good step increments good_cnt. When good_cnt reaches LOCK_N, go to LOCKED.
  - A mismatch sets good_cnt ← 0 and stays in SYNC. Errors are not counted in SYNC.
- In LOCKED:
  - A good step stays in LOCKED.
  - A mismatch raises err_pulse for one cycle, increments err_count (saturating at 2^STAT_W−1), sets good_cnt ← 0 and goes to SYNC.
- A good step from 2^CNT_W−1 to 0 increments wrap_count in SYNC or LOCKED. wrap_count wraps modulo 2^STAT_W.
- locked = (state == LOCKED), driven as a registered output.
- clear has priority over sampling. It returns the block to IDLE, zeroes all stats and history, and captures no sample that cycle.
- The reset value of every output is 0, and the state resets to IDLE.

## Timing
- All outputs are registered.
- The comparison of the sample taken at edge k against the sample from edge k−1 is visible just after edge k.
- Lock latency from reset release, with a clean sequence: locked rises at the edge that captures sample LOCK_N+1 (the third sample for the default).
- err_pulse is high for exactly the one cycle following the edge that captured the bad sample.
- reset asserted mid-operation forces all outputs to 0 immediately, without waiting for clk. Operation restarts in IDLE on the first edge after release.
- Simultaneous error and wrap cannot occur, because a wrap is by definition a good step.
- Simultaneous clear and a bad sample: clear wins and no err_pulse is raised.

## Structure
- Package count_mon_pkg holds:
  - the state enum typedef (IDLE, SYNC, LOCKED);
  - the default CNT_W constant shared with binary_counter;
  - a next_count(prev) function that computes prev + 1 modulo 2^CNT_W.
- Sub-module count_history_sr: parameterised CNT_W×DEPTH shift register with async reset, sync clear and shift enable.
- The top module holds the FSM, the comparator, good_cnt and the two stat counters.

## Test plan
- Reset, then feed 0,1,2,3 on consecutive edges:
  - locked = 0 after samples 1 and 2;
  - locked = 1 after sample 3;
  - err_count = 0.
- Lock, then feed 4,5,6,7,0:
  - wrap_count = 1 after the edge that samples 0;
  - after sample 7, history = 12'b100_101_110_111.
- Locked at 3, then feed 5:
  - err_pulse high for exactly one cycle, err_count = 1, locked = 0;
  - feeding 6,7,0 re-asserts locked after the sample of 7.
- Locked, then hold count_in at 2 for two edges:
  - exactly one error is counted (err_count = 1);
  - locked stays 0 until two further good steps follow.
- Force err_count to 255 with repeated lock/glitch cycles, then inject one more error:
  - err_count stays 255;
  - err_pulse still pulses.
- With locked = 1 and wrap_count = 3:
  - assert reset between clock edges and check all outputs read 0 before the next edge;
  - separately, assert clear together with a bad sample and check state is IDLE with no err_pulse.
